// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side controllers.
// The defaults here are also picked up by the write-side controller.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b01,
      ST_READ = 2'b10
   } state_t;

   localparam int DEF_N_CH      = 4;
   localparam int DEF_BURST_LEN = 8;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after base, wrapping.
module rr_arbiter #(
   parameter int N_CH = 4,
   parameter int CH_W = 2
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] base,
   output logic            gnt_valid,
   output logic [CH_W-1:0] gnt_idx
);

   logic [N_CH-1:0] w_rot;
   int              w_off;
   int              w_sum;

   // Rotate so that bit 0 is the base channel; the lowest set bit wins.
   assign w_rot = N_CH'({req, req} >> base);

   always_comb begin
      gnt_valid = 1'b0;
      w_off     = 0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            gnt_valid = 1'b1;
            w_off     = i;
         end
      end
      w_sum = int'(base) + w_off;
      if (w_sum >= N_CH) begin
         w_sum = w_sum - N_CH;
      end
      gnt_idx = CH_W'(w_sum);
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Burst read arbiter over N_CH FIFOs: round-robin grant, up to BURST_LEN reads
// per grant under backpressure, with a data_valid/data_ch strobe aligned to FIFO output.
module fifo_rd_arbiter
   import fifo_rd_pkg::*;
#(
   parameter int N_CH       = DEF_N_CH,
   parameter int BURST_LEN  = DEF_BURST_LEN,
   parameter int RD_LATENCY = 1,
   parameter int CH_W       = (N_CH > 1) ? clog2(N_CH) : 1,
   parameter int CNT_W      = clog2(BURST_LEN + 1)
) (
   input  logic            rd_clk,
   input  logic            reset_n,
   input  logic [N_CH-1:0] empty,
   input  logic            ds_ready,
   output logic [N_CH-1:0] rd_en,
   output logic [CH_W-1:0] grant_ch,
   output logic            busy,
   output logic            burst_done,
   output logic            data_valid,
   output logic [CH_W-1:0] data_ch,
   output logic [1:0]      dbg_state
);

   // Handshake: a word moves from FIFO grant_ch in any cycle where rd_en is high;
   // rd_en is only raised when that FIFO is non-empty and ds_ready is high.

   state_t          r_state;
   logic [CH_W-1:0] r_grant;
   logic [CH_W-1:0] r_last;
   logic [CNT_W-1:0] r_cnt;
   logic            r_burst_done;
   logic [RD_LATENCY-1:0] r_vld_pipe;
   logic [CH_W-1:0] r_ch_pipe [RD_LATENCY];

   logic [CH_W-1:0] w_base;
   logic            w_gnt_valid;
   logic [CH_W-1:0] w_gnt_idx;
   logic            w_empty_gnt;
   logic            w_rd;
   logic            w_last_read;

   always_comb begin
      w_base = (r_last == CH_W'(N_CH - 1)) ? '0 : r_last + 1'b1;
   end

   rr_arbiter #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_rr (
      .req       (~empty),
      .base      (w_base),
      .gnt_valid (w_gnt_valid),
      .gnt_idx   (w_gnt_idx)
   );

   assign w_empty_gnt = empty[r_grant];
   assign w_rd        = (r_state == ST_READ) && !w_empty_gnt && ds_ready;
   assign w_last_read = (r_cnt == CNT_W'(BURST_LEN - 1));

   always_comb begin
      rd_en = '0;
      if (w_rd) begin
         rd_en[r_grant] = 1'b1;
      end
   end

   // An empty granted FIFO ends the burst even if the same cycle would have been the last read.
   always_ff @(posedge rd_clk) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last       <= CH_W'(N_CH - 1);
         r_cnt        <= '0;
         r_burst_done <= 1'b0;
      end else begin
         r_burst_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_valid) begin
                  r_grant <= w_gnt_idx;
                  r_cnt   <= '0;
                  r_state <= ST_READ;
               end
            end
            ST_READ: begin
               if (w_empty_gnt || (w_rd && w_last_read)) begin
                  r_state      <= ST_IDLE;
                  r_last       <= r_grant;
                  r_burst_done <= 1'b1;
               end
               if (w_rd) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge rd_clk) begin
      if (!reset_n) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            r_vld_pipe[i] <= 1'b0;
            r_ch_pipe[i]  <= '0;
         end
      end else begin
         r_vld_pipe[0] <= w_rd;
         r_ch_pipe[0]  <= r_grant;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_ch_pipe[i]  <= r_ch_pipe[i-1];
         end
      end
   end

   assign grant_ch   = r_grant;
   assign busy       = (r_state == ST_READ);
   assign burst_done = r_burst_done;
   assign data_valid = r_vld_pipe[RD_LATENCY-1];
   assign data_ch    = r_ch_pipe[RD_LATENCY-1];
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a word-count model of each input FIFO.
module tb_fifo_rd_arbiter;

   localparam int N_CH       = 4;
   localparam int BURST_LEN  = 8;
   localparam int RD_LATENCY = 1;
   localparam int CH_W       = 2;

   // ---------------- clock / reset ----------------
   logic rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   logic            reset_n;
   logic [N_CH-1:0] empty;
   logic            ds_ready;
   logic [N_CH-1:0] rd_en;
   logic [CH_W-1:0] grant_ch;
   logic            busy;
   logic            burst_done;
   logic            data_valid;
   logic [CH_W-1:0] data_ch;
   logic [1:0]      dbg_state;

   fifo_rd_arbiter #(
      .N_CH       (N_CH),
      .BURST_LEN  (BURST_LEN),
      .RD_LATENCY (RD_LATENCY)
   ) dut (
      .rd_clk     (rd_clk),
      .reset_n    (reset_n),
      .empty      (empty),
      .ds_ready   (ds_ready),
      .rd_en      (rd_en),
      .grant_ch   (grant_ch),
      .busy       (busy),
      .burst_done (burst_done),
      .data_valid (data_valid),
      .data_ch    (data_ch),
      .dbg_state  (dbg_state)
   );

   // ---------------- bench state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int fcnt [N_CH];
   int tot_rd [N_CH];
   int cyc = 0;

   logic [N_CH-1:0] c_rd;
   logic            c_busy, c_dv, c_bd;
   logic [CH_W-1:0] c_dch, c_gnt;
   logic [1:0]      c_state;

   logic            prev_busy = 1'b0;
   logic            prev_rd_any = 1'b0;
   logic [CH_W-1:0] prev_gnt = '0;

   int cur_burst, onehot_err, dv_err, ds_viol, act_cnt, bd_cnt, last_rd_cyc, bd_cyc, off_gnt;
   int              burst_q[$];
   logic [CH_W-1:0] gnt_q[$];
   logic [CH_W-1:0] exp_q[$];

   // ---------------- scoreboard check ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic update_empty();
      for (int c = 0; c < N_CH; c++) empty[c] = (fcnt[c] == 0);
   endtask

   function automatic logic all_zero();
      logic z;
      z = 1'b1;
      for (int c = 0; c < N_CH; c++) if (fcnt[c] != 0) z = 1'b0;
      return z;
   endfunction

   task automatic clear_stats();
      cur_burst = 0; onehot_err = 0; dv_err = 0; ds_viol = 0; act_cnt = 0;
      bd_cnt = 0; last_rd_cyc = 0; bd_cyc = 0; off_gnt = 0;
      burst_q.delete(); gnt_q.delete(); exp_q.delete();
      for (int c = 0; c < N_CH; c++) tot_rd[c] = 0;
   endtask

   // One clock cycle: inputs are set at posedge+1, outputs sampled at negedge,
   // and the FIFO model consumes the words read in this cycle just after posedge.
   task automatic step(input logic ds);
      logic exp_dv;
      ds_ready = ds;
      @(negedge rd_clk);
      c_rd = rd_en; c_busy = busy; c_dv = data_valid; c_dch = data_ch;
      c_gnt = grant_ch; c_bd = burst_done; c_state = dbg_state;
      exp_dv = prev_rd_any;
      if (c_dv !== exp_dv) dv_err++;
      if (exp_dv && (c_dch !== prev_gnt)) dv_err++;
      if ($countones(c_rd) > 1) onehot_err++;
      if ((c_rd != 0) && !ds) ds_viol++;
      if (c_rd != 0 || c_busy || c_dv) act_cnt++;
      if (c_busy && !prev_busy) gnt_q.push_back(c_gnt);
      if (c_busy && (c_gnt != 2'd2)) off_gnt++;
      if (c_rd != 0) begin
         cur_burst++;
         last_rd_cyc = cyc;
      end
      if (c_bd === 1'b1) begin
         burst_q.push_back(cur_burst);
         cur_burst = 0;
         bd_cnt++;
         bd_cyc = cyc;
      end
      prev_rd_any = (c_rd != 0) && reset_n;
      prev_gnt    = c_gnt;
      prev_busy   = (c_busy === 1'b1);
      @(posedge rd_clk);
      #1;
      for (int c = 0; c < N_CH; c++) begin
         if (c_rd[c] === 1'b1 && fcnt[c] > 0) begin
            fcnt[c]--;
            tot_rd[c]++;
         end
      end
      update_empty();
      cyc++;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      for (int c = 0; c < N_CH; c++) fcnt[c] = 0;
      update_empty();
      for (int i = 0; i < 3; i++) step(1'b1);
      reset_n = 1'b1;
      clear_stats();
   endtask

   task automatic run_drain(input string tag, input int max);
      int n;
      logic done;
      n = 0;
      done = 1'b0;
      while (!done && n < max) begin
         step(1'b1);
         n++;
         done = all_zero() && (c_state == 2'b01);
      end
      check(tag, done, 1'b1);
   endtask

   task automatic run_to_done(input string tag, input logic [3:0] pat, input int max);
      int n;
      n = 0;
      while (bd_cnt == 0 && n < max) begin
         step(pat[n % 4]);
         n++;
      end
      check(tag, bd_cnt, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int reads;
      int n;
      reset_n  = 1'b0;
      ds_ready = 1'b1;
      for (int c = 0; c < N_CH; c++) fcnt[c] = 0;
      update_empty();
      clear_stats();
      @(posedge rd_clk);
      #1;

      // Reset values
      do_reset();
      check("rst_rd_en", c_rd, 0);
      check("rst_busy", c_busy, 0);
      check("rst_burst_done", c_bd, 0);
      check("rst_data_valid", c_dv, 0);
      check("rst_data_ch", c_dch, 0);
      check("rst_grant_ch", c_gnt, 0);
      check("rst_state", c_state, 2'b01);

      // All FIFOs empty: nothing happens for 20 cycles
      for (int i = 0; i < 20; i++) step(1'b1);
      check("idle_activity", act_cnt, 0);

      // ch0 holds 20 words: bursts of 8, 8, 4
      do_reset();
      fcnt[0] = 20;
      update_empty();
      run_drain("ch0_drain", 200);
      check("ch0_reads", tot_rd[0], 20);
      check("ch0_bursts", burst_q.size(), 3);
      if (burst_q.size() == 3) begin
         check("ch0_burst0", burst_q[0], 8);
         check("ch0_burst1", burst_q[1], 8);
         check("ch0_burst2", burst_q[2], 4);
      end
      check("ch0_dv_align", dv_err, 0);

      // All four FIFOs hold 16 words: round-robin order 0,1,2,3,0,1,2,3
      do_reset();
      for (int c = 0; c < N_CH; c++) fcnt[c] = 16;
      update_empty();
      run_drain("rr_drain", 400);
      for (int k = 0; k < 8; k++) exp_q.push_back(CH_W'(k % N_CH));
      check("rr_grants", gnt_q.size(), 8);
      if (gnt_q.size() == 8) begin
         for (int k = 0; k < 8; k++) check($sformatf("rr_order%0d", k), gnt_q[k], exp_q[k]);
      end
      check("rr_total", tot_rd[0] + tot_rd[1] + tot_rd[2] + tot_rd[3], 64);
      check("rr_onehot", onehot_err, 0);
      check("rr_dv_align", dv_err, 0);

      // ds_ready pattern 1,0,0,1 during a ch2 burst
      do_reset();
      fcnt[2] = 20;
      update_empty();
      run_to_done("bp_done", 4'b1001, 200);
      check("bp_reads", tot_rd[2], 8);
      check("bp_ds_viol", ds_viol, 0);
      check("bp_grant", off_gnt, 0);
      check("bp_dv_align", dv_err, 0);

      // ch1 holds 3 words: short burst ended by empty
      do_reset();
      fcnt[1] = 3;
      update_empty();
      run_to_done("short_done", 4'b1111, 100);
      check("short_reads", tot_rd[1], 3);
      check("short_gap", bd_cyc - last_rd_cyc, 2);
      check("short_state", c_state, 2'b01);
      step(1'b1);
      check("short_no_more", c_busy, 0);

      // Reset during the 5th read of a ch2 burst
      do_reset();
      fcnt[2] = 20;
      update_empty();
      reads = 0;
      n = 0;
      while (reads < 4 && n < 50) begin
         step(1'b1);
         if (c_rd[2]) reads++;
         n++;
      end
      check("mr_four_reads", reads, 4);
      fcnt[1] = 5;
      update_empty();
      reset_n = 1'b0;
      step(1'b1);
      check("mr_fifth_read", c_rd, 4'b0100);
      reset_n = 1'b1;
      step(1'b1);
      check("mr_rd_en", c_rd, 0);
      check("mr_state", c_state, 2'b01);
      check("mr_data_valid", c_dv, 0);
      step(1'b1);
      check("mr_busy", c_busy, 1);
      check("mr_regrant", c_gnt, 1);

      // ---------------- final report ----------------
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
